// File: rtl/z3_reg_window_if.sv
`default_nettype none
// =============================================================================
// Module   : z3_reg_window_if
// Brief    : Zorro III slave-cycle bus bundle seen by a register window.
// Revision : 1.0 - initial release
// =============================================================================
interface z3_reg_window_if;
  logic [21:0] ADDR;
  logic        READ;
  logic [7:0]  DIN;
  logic        FCS_n;
  logic        slave_cycle;
  logic        configured;
  logic        SEL_n;
  logic [7:0]  DOUT;
  logic        DTACK;

  modport master (
    output ADDR, READ, DIN, FCS_n, slave_cycle, configured,
    input  SEL_n, DOUT, DTACK
  );

  modport slave (
    input  ADDR, READ, DIN, FCS_n, slave_cycle, configured,
    output SEL_n, DOUT, DTACK
  );
endinterface
`default_nettype wire

// File: rtl/z3_reg_window.sv
`default_nettype none
// =============================================================================
// Module   : z3_reg_window
// Brief    : Z3 register-window slave with NREGS byte registers and
//            programmable DTACK wait states. Optional lock register when
//            Z3_REG_LOCK_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module z3_reg_window #(
  parameter int                 NREGS       = 4,
  parameter logic [6:0]         BASE        = 7'h46,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [NREGS*8-1:0] RESET_VAL   = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  z3_reg_window_if.slave     bus,
  output logic [NREGS*8-1:0] REG_Q
);

  localparam int             c_IW      = $clog2(NREGS);
  localparam logic [c_IW:0]  c_NREGS   = (c_IW + 1)'(NREGS);
  localparam logic [3:0]     c_WAIT    = 4'(WAIT_CYCLES);
  localparam logic [1:0]     c_ST_IDLE = 2'd0;
  localparam logic [1:0]     c_ST_WAIT = 2'd1;
  localparam logic [1:0]     c_ST_HOLD = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_IW-1:0] r_idx;
  logic            r_read;
  logic [3:0]      r_cnt;
  logic [7:0]      r_dout;
  logic            r_dtack;
  logic            w_sel;
  logic            w_latch;
  logic            w_access;
  logic            w_idx_ok;
  logic            w_wr_go;
  logic            w_data_wr;
  logic [7:0]      w_rd_data;
  logic            w_unused_addr;

  assign w_sel         = bus.slave_cycle && bus.configured && (bus.ADDR[21:15] == BASE);
  assign bus.SEL_n     = !w_sel;
  assign bus.DOUT      = r_dout;
  assign bus.DTACK     = r_dtack;
  assign w_unused_addr = ^bus.ADDR[14:c_IW];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_sel && !bus.FCS_n) w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: begin
        if (bus.FCS_n)          w_state_nxt = c_ST_IDLE;
        else if (r_cnt == 4'd0) w_state_nxt = c_ST_HOLD;
      end
      c_ST_HOLD: if (bus.FCS_n) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch  = 1'b0;
    w_access = 1'b0;
    case (r_state)
      c_ST_IDLE: w_latch  = w_sel && !bus.FCS_n;
      c_ST_WAIT: w_access = !bus.FCS_n && (r_cnt == 4'd0);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx   <= '0;
      r_read  <= 1'b0;
      r_cnt   <= 4'd0;
      r_dout  <= 8'hFF;
      r_dtack <= 1'b0;
    end else begin
      if (w_latch) begin
        r_idx  <= bus.ADDR[c_IW-1:0];
        r_read <= bus.READ;
        r_cnt  <= c_WAIT;
      end else if (r_state == c_ST_WAIT && !bus.FCS_n && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && r_read) r_dout <= w_rd_data;
      r_dtack <= (w_state_nxt == c_ST_HOLD);
    end
  end

  // Only non-power-of-two windows can address a missing register.
  generate
    if (NREGS == (1 << c_IW)) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = ({1'b0, r_idx} < c_NREGS);
    end
  endgenerate

  always_comb begin
    w_rd_data = 8'hFF;
    if (w_idx_ok) begin
      for (int i = 0; i < NREGS; i++) begin
        if (r_idx == c_IW'(i)) w_rd_data = REG_Q[i*8 +: 8];
      end
    end
  end

  assign w_wr_go = w_access && !r_read && w_idx_ok;

`ifdef Z3_REG_LOCK_EN
  logic r_locked;
  logic w_lock_slot;

  assign w_lock_slot = (r_idx == c_IW'(NREGS - 1));
  assign w_data_wr   = w_wr_go && !w_lock_slot && !r_locked;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_locked <= 1'b0;
    end else if (w_wr_go && w_lock_slot) begin
      if (bus.DIN == 8'hA5)      r_locked <= 1'b1;
      else if (bus.DIN == 8'h5A) r_locked <= 1'b0;
    end
  end
`else
  assign w_data_wr = w_wr_go;
`endif

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
      localparam logic [c_IW-1:0] c_I = c_IW'(i);
`ifdef Z3_REG_LOCK_EN
      if (i == NREGS - 1) begin : g_lock
        assign REG_Q[i*8 +: 8] = {7'b0, r_locked};
      end else begin : g_data
        logic [7:0] r_q;
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET)                         r_q <= RESET_VAL[i*8 +: 8];
          else if (w_data_wr && r_idx == c_I) r_q <= bus.DIN;
        end
        assign REG_Q[i*8 +: 8] = r_q;
      end
`else
      begin : g_data
        logic [7:0] r_q;
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET)                         r_q <= RESET_VAL[i*8 +: 8];
          else if (w_data_wr && r_idx == c_I) r_q <= bus.DIN;
        end
        assign REG_Q[i*8 +: 8] = r_q;
      end
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_z3_reg_window.sv
`default_nettype none
// =============================================================================
// Module   : tb_z3_reg_window
// Brief    : Directed self-checking bench for z3_reg_window (three parameter sets).
// Revision : 1.0 - initial release
// =============================================================================
module tb_z3_reg_window;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  z3_reg_window_if ba ();
  z3_reg_window_if bb ();
  z3_reg_window_if bc ();

  logic [31:0] qa;
  logic [23:0] qb;
  logic [31:0] qc;

  z3_reg_window #(.NREGS(4), .BASE(7'h46), .WAIT_CYCLES(0), .RESET_VAL(32'h44332211))
    u_a (.CLK(CLK), .RESET(RESET), .bus(ba.slave), .REG_Q(qa));
  z3_reg_window #(.NREGS(3), .BASE(7'h46), .WAIT_CYCLES(3), .RESET_VAL(24'hC3B2A1))
    u_b (.CLK(CLK), .RESET(RESET), .bus(bb.slave), .REG_Q(qb));
  z3_reg_window #(.NREGS(4), .BASE(7'h46), .WAIT_CYCLES(5), .RESET_VAL(32'h0))
    u_c (.CLK(CLK), .RESET(RESET), .bus(bc.slave), .REG_Q(qc));

`ifdef Z3_REG_LOCK_EN
  localparam logic [31:0] c_A_RST = 32'h00332211;
`else
  localparam logic [31:0] c_A_RST = 32'h44332211;
`endif
  localparam logic [23:0] c_B_RST = 24'hC3B2A1;
  localparam logic [31:0] c_C_RST = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [21:0] mk(input logic [6:0] b, input int idx);
    return {b, 15'(idx)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int u, input logic [21:0] a, input logic rd,
                       input logic [7:0] d, input logic fcs);
    case (u)
      0:       begin ba.ADDR = a; ba.READ = rd; ba.DIN = d; ba.FCS_n = fcs; end
      1:       begin bb.ADDR = a; bb.READ = rd; bb.DIN = d; bb.FCS_n = fcs; end
      default: begin bc.ADDR = a; bc.READ = rd; bc.DIN = d; bc.FCS_n = fcs; end
    endcase
  endtask

  task automatic set_fcs(input int u, input logic v);
    case (u)
      0:       ba.FCS_n = v;
      1:       bb.FCS_n = v;
      default: bc.FCS_n = v;
    endcase
  endtask

  function automatic logic obs_dtack(input int u);
    case (u)
      0:       return ba.DTACK;
      1:       return bb.DTACK;
      default: return bc.DTACK;
    endcase
  endfunction

  function automatic logic [7:0] obs_dout(input int u);
    case (u)
      0:       return ba.DOUT;
      1:       return bb.DOUT;
      default: return bc.DOUT;
    endcase
  endfunction

  // Full strobe: no early ack, ack exactly at edge n+1+w, drop one edge after release.
  task automatic do_access(input int u, input logic [21:0] a, input logic rd,
                           input logic [7:0] d, input int w, output logic ok);
    logic early, ack, drop;
    early = 1'b0;
    drive(u, a, rd, d, 1'b0);
    for (int k = 0; k <= w; k++) begin
      tick();
      early |= obs_dtack(u);
    end
    tick();
    ack = obs_dtack(u);
    set_fcs(u, 1'b1);
    tick();
    drop = !obs_dtack(u);
    ok = !early && ack && drop;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL rst_dtack_a: got %b expected 0", ba.DTACK); end
    n_checks++; if (bb.DTACK !== 1'b0) begin n_fail++; $display("FAIL rst_dtack_b: got %b expected 0", bb.DTACK); end
    n_checks++; if (ba.DOUT !== 8'hFF) begin n_fail++; $display("FAIL rst_dout_a: got %h expected ff", ba.DOUT); end
    n_checks++; if (bc.DOUT !== 8'hFF) begin n_fail++; $display("FAIL rst_dout_c: got %h expected ff", bc.DOUT); end
    n_checks++; if (qa !== c_A_RST) begin n_fail++; $display("FAIL rst_regq_a: got %h expected %h", qa, c_A_RST); end
    n_checks++; if (qb !== c_B_RST) begin n_fail++; $display("FAIL rst_regq_b: got %h expected %h", qb, c_B_RST); end
    n_checks++; if (qc !== c_C_RST) begin n_fail++; $display("FAIL rst_regq_c: got %h expected %h", qc, c_C_RST); end
    n_checks++; if (ba.SEL_n !== 1'b0) begin n_fail++; $display("FAIL rst_sel_a: got %b expected 0", ba.SEL_n); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    drive(0, mk(7'h46, 1), 1'b0, 8'h99, 1'b0);
    tick();
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL wr_dtack_n: got %b expected 0", ba.DTACK); end
    ba.DIN = 8'h3C;
    tick();
    n_checks++; if (ba.DTACK !== 1'b1) begin n_fail++; $display("FAIL wr_dtack_n1: got %b expected 1", ba.DTACK); end
    n_checks++; if (qa[15:8] !== 8'h3C) begin n_fail++; $display("FAIL wr_regq: got %h expected 3c", qa[15:8]); end
    ba.FCS_n = 1'b1;
    tick();
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL wr_dtack_drop: got %b expected 0", ba.DTACK); end
    drive(0, mk(7'h46, 1), 1'b1, 8'h00, 1'b0);
    tick();
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL rd_dtack_n: got %b expected 0", ba.DTACK); end
    tick();
    n_checks++; if (ba.DTACK !== 1'b1) begin n_fail++; $display("FAIL rd_dtack_n1: got %b expected 1", ba.DTACK); end
    n_checks++; if (ba.DOUT !== 8'h3C) begin n_fail++; $display("FAIL rd_dout: got %h expected 3c", ba.DOUT); end
    ba.FCS_n = 1'b1;
    tick();
  endtask

  task automatic test_wait_hold();
    logic held;
    drive(1, mk(7'h46, 2), 1'b1, 8'h00, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      tick();
      // Retarget the address after latch: must not disturb the latched index.
      if (k == 0) begin bb.ADDR = mk(7'h47, 0); bb.READ = 1'b0; end
      n_checks++;
      if (bb.DTACK !== (k == 4)) begin n_fail++; $display("FAIL w3_latency edge%0d: got %b expected %b", k, bb.DTACK, (k == 4)); end
    end
    n_checks++; if (bb.DOUT !== 8'hC3) begin n_fail++; $display("FAIL w3_dout: got %h expected c3", bb.DOUT); end
    bb.FCS_n = 1'b1;
    tick();
    drive(1, mk(7'h46, 0), 1'b0, 8'h5E, 1'b0);
    for (int k = 0; k <= 4; k++) tick();
    n_checks++; if (qb[7:0] !== 8'h5E) begin n_fail++; $display("FAIL w3_write: got %h expected 5e", qb[7:0]); end
    bb.DIN = 8'h00;
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      held &= bb.DTACK;
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL hold_dtack: got %b expected 1", held); end
    n_checks++; if (qb[7:0] !== 8'h5E) begin n_fail++; $display("FAIL hold_single: got %h expected 5e", qb[7:0]); end
    bb.FCS_n = 1'b1;
    tick();
    n_checks++; if (bb.DTACK !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b expected 0", bb.DTACK); end
  endtask

  task automatic test_abort();
    logic any_ack, ok;
    any_ack = 1'b0;
    drive(2, mk(7'h46, 1), 1'b0, 8'h77, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); any_ack |= bc.DTACK; end
    bc.FCS_n = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); any_ack |= bc.DTACK; end
    n_checks++; if (any_ack !== 1'b0) begin n_fail++; $display("FAIL abort_dtack: got %b expected 0", any_ack); end
    n_checks++; if (qc[15:8] !== 8'h00) begin n_fail++; $display("FAIL abort_reg: got %h expected 00", qc[15:8]); end
    do_access(2, mk(7'h46, 1), 1'b0, 8'h77, 5, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_retry_ack: got %b expected 1", ok); end
    n_checks++; if (qc[15:8] !== 8'h77) begin n_fail++; $display("FAIL abort_retry_reg: got %h expected 77", qc[15:8]); end
  endtask

  task automatic test_decode();
    logic any_ack;
    drive(0, mk(7'h47, 1), 1'b0, 8'hEE, 1'b0);
    #1;
    n_checks++; if (ba.SEL_n !== 1'b1) begin n_fail++; $display("FAIL dec_base_sel: got %b expected 1", ba.SEL_n); end
    any_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); any_ack |= ba.DTACK; end
    ba.FCS_n = 1'b1;
    ba.ADDR = mk(7'h46, 1);
    ba.configured = 1'b0;
    #1;
    n_checks++; if (ba.SEL_n !== 1'b1) begin n_fail++; $display("FAIL dec_cfg_sel: got %b expected 1", ba.SEL_n); end
    ba.FCS_n = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); any_ack |= ba.DTACK; end
    ba.FCS_n = 1'b1;
    ba.configured = 1'b1;
    ba.slave_cycle = 1'b0;
    #1;
    n_checks++; if (ba.SEL_n !== 1'b1) begin n_fail++; $display("FAIL dec_slave_sel: got %b expected 1", ba.SEL_n); end
    ba.FCS_n = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); any_ack |= ba.DTACK; end
    n_checks++; if (any_ack !== 1'b0) begin n_fail++; $display("FAIL dec_no_ack: got %b expected 0", any_ack); end
    n_checks++; if (qa[15:8] !== 8'h3C) begin n_fail++; $display("FAIL dec_reg: got %h expected 3c", qa[15:8]); end
    ba.FCS_n = 1'b1;
    ba.slave_cycle = 1'b1;
    #1;
    n_checks++; if (ba.SEL_n !== 1'b0) begin n_fail++; $display("FAIL dec_restore_sel: got %b expected 0", ba.SEL_n); end
    tick();
  endtask

  task automatic test_out_of_range();
    logic ok;
    do_access(1, mk(7'h46, 3), 1'b1, 8'h00, 3, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL oor_rd_ack: got %b expected 1", ok); end
    n_checks++; if (bb.DOUT !== 8'hFF) begin n_fail++; $display("FAIL oor_rd_dout: got %h expected ff", bb.DOUT); end
    do_access(1, mk(7'h46, 3), 1'b0, 8'h12, 3, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ack: got %b expected 1", ok); end
    n_checks++; if (qb !== 24'hC3B25E) begin n_fail++; $display("FAIL oor_wr_regq: got %h expected c3b25e", qb); end
  endtask

`ifdef Z3_REG_LOCK_EN
  task automatic test_lock();
    logic ok;
    do_access(0, mk(7'h46, 3), 1'b0, 8'hA5, 0, ok);
    n_checks++; if (qa[31:24] !== 8'h01) begin n_fail++; $display("FAIL lock_set: got %h expected 01", qa[31:24]); end
    do_access(0, mk(7'h46, 0), 1'b0, 8'h6B, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lock_wr_ack: got %b expected 1", ok); end
    n_checks++; if (qa[7:0] !== 8'h11) begin n_fail++; $display("FAIL lock_wr_blocked: got %h expected 11", qa[7:0]); end
    do_access(0, mk(7'h46, 3), 1'b1, 8'h00, 0, ok);
    n_checks++; if (ba.DOUT !== 8'h01) begin n_fail++; $display("FAIL lock_rd: got %h expected 01", ba.DOUT); end
    do_access(0, mk(7'h46, 3), 1'b0, 8'h33, 0, ok);
    n_checks++; if (qa[31:24] !== 8'h01) begin n_fail++; $display("FAIL lock_other: got %h expected 01", qa[31:24]); end
    do_access(0, mk(7'h46, 3), 1'b0, 8'h5A, 0, ok);
    n_checks++; if (qa[31:24] !== 8'h00) begin n_fail++; $display("FAIL lock_clear: got %h expected 00", qa[31:24]); end
    do_access(0, mk(7'h46, 0), 1'b0, 8'h6B, 0, ok);
    n_checks++; if (qa[7:0] !== 8'h6B) begin n_fail++; $display("FAIL lock_retry: got %h expected 6b", qa[7:0]); end
  endtask
`else
  task automatic test_lock();
    logic ok;
    do_access(0, mk(7'h46, 3), 1'b0, 8'h9D, 0, ok);
    n_checks++; if (qa[31:24] !== 8'h9D) begin n_fail++; $display("FAIL top_reg_wr: got %h expected 9d", qa[31:24]); end
    do_access(0, mk(7'h46, 3), 1'b1, 8'h00, 0, ok);
    n_checks++; if (ba.DOUT !== 8'h9D) begin n_fail++; $display("FAIL top_reg_rd: got %h expected 9d", ba.DOUT); end
    do_access(0, mk(7'h46, 3), 1'b0, 8'hA5, 0, ok);
    do_access(0, mk(7'h46, 0), 1'b0, 8'h6B, 0, ok);
    n_checks++; if (qa[7:0] !== 8'h6B) begin n_fail++; $display("FAIL no_lock_wr: got %h expected 6b", qa[7:0]); end
  endtask
`endif

  task automatic test_reset_mid();
    drive(0, mk(7'h46, 2), 1'b0, 8'hE7, 1'b0);
    tick();
    tick();
    n_checks++; if (ba.DTACK !== 1'b1) begin n_fail++; $display("FAIL mid_pre_dtack: got %b expected 1", ba.DTACK); end
    n_checks++; if (qa[23:16] !== 8'hE7) begin n_fail++; $display("FAIL mid_pre_reg: got %h expected e7", qa[23:16]); end
    RESET = 1'b1;
    #1;
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL mid_async_dtack: got %b expected 0", ba.DTACK); end
    n_checks++; if (qa !== c_A_RST) begin n_fail++; $display("FAIL mid_regq: got %h expected %h", qa, c_A_RST); end
    n_checks++; if (ba.DOUT !== 8'hFF) begin n_fail++; $display("FAIL mid_dout: got %h expected ff", ba.DOUT); end
    ba.FCS_n = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    n_checks++; if (ba.DTACK !== 1'b0) begin n_fail++; $display("FAIL mid_post_dtack: got %b expected 0", ba.DTACK); end
  endtask

  initial begin
    ba.slave_cycle = 1'b1; ba.configured = 1'b1;
    bb.slave_cycle = 1'b1; bb.configured = 1'b1;
    bc.slave_cycle = 1'b1; bc.configured = 1'b1;
    drive(0, mk(7'h46, 0), 1'b1, 8'h00, 1'b1);
    drive(1, mk(7'h46, 0), 1'b1, 8'h00, 1'b1);
    drive(2, mk(7'h46, 0), 1'b1, 8'h00, 1'b1);
    test_reset();
    test_write_read();
    test_wait_hold();
    test_abort();
    test_decode();
    test_out_of_range();
    test_lock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
